// File: rtl/int_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : int_alu_pkg
//  Purpose  : Shared widths, ALU operation codes and arbiter state encoding
//             for the shared integer ALU arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package int_alu_pkg;

    localparam int DATA_W   = 32;
    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] OP_ADD     = 4'b0000;
    localparam logic [ALU_OP_W-1:0] OP_SUB     = 4'b0001;
    localparam logic [ALU_OP_W-1:0] OP_MUL     = 4'b0010;
    localparam logic [ALU_OP_W-1:0] OP_DIV     = 4'b0011;
    localparam logic [ALU_OP_W-1:0] OP_NOT     = 4'b0100;
    localparam logic [ALU_OP_W-1:0] OP_AND     = 4'b0101;
    localparam logic [ALU_OP_W-1:0] OP_OR      = 4'b0110;
    localparam logic [ALU_OP_W-1:0] OP_XOR     = 4'b0111;
    localparam logic [ALU_OP_W-1:0] OP_WR_HIGH = 4'b1000;
    localparam logic [ALU_OP_W-1:0] OP_WR_LOW  = 4'b1001;
    localparam logic [ALU_OP_W-1:0] OP_ITOF    = 4'b1010;
    localparam logic [ALU_OP_W-1:0] OP_FTOI    = 4'b1011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Only the arithmetic group (op[3:2]==00) produces a meaningful flag.
    function automatic logic flag_kept(input logic [ALU_OP_W-1:0] op);
        return (op[3:2] == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/int_alu_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : int_alu_arbiter_if
//  Purpose  : Requester, ALU and response bundle of the shared ALU arbiter.
//             slave = arbiter side, master = core/ALU environment side.
//  Revision : 1.0 - initial release
// ============================================================================
interface int_alu_arbiter_if
    import int_alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 5
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*DATA_W-1:0]   req_op1;
    logic [NUM_REQ*DATA_W-1:0]   req_op2;
    logic [NUM_REQ*ALU_OP_W-1:0] req_operation;
    logic [NUM_REQ*TAG_W-1:0]    req_tag;

    logic [DATA_W-1:0]           alu_op1;
    logic [DATA_W-1:0]           alu_op2;
    logic [ALU_OP_W-1:0]         alu_operation;
    logic                        alu_en;
    logic [DATA_W-1:0]           alu_out;
    logic                        alu_done;
    logic [1:0]                  alu_flag;

    logic                        resp_valid;
    logic                        resp_ready;
    logic [ID_W-1:0]             resp_id;
    logic [TAG_W-1:0]            resp_tag;
    logic [DATA_W-1:0]           resp_data;
    logic [1:0]                  resp_flag;
    logic                        resp_timeout;

    modport slave (
        input  req_valid, req_op1, req_op2, req_operation, req_tag,
        output req_ready,
        output alu_op1, alu_op2, alu_operation, alu_en,
        input  alu_out, alu_done, alu_flag,
        output resp_valid, resp_id, resp_tag, resp_data, resp_flag, resp_timeout,
        input  resp_ready
    );

    modport master (
        output req_valid, req_op1, req_op2, req_operation, req_tag,
        input  req_ready,
        input  alu_op1, alu_op2, alu_operation, alu_en,
        output alu_out, alu_done, alu_flag,
        input  resp_valid, resp_id, resp_tag, resp_data, resp_flag, resp_timeout,
        output resp_ready
    );

endinterface
`default_nettype wire

// File: rtl/int_alu_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational rotating-priority grant. Searches i_ptr,
//             i_ptr+1, ... mod NUM_REQ and returns a one-hot grant + index.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    int w_slot;

    // First valid requester at or after the pointer wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_slot  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_slot = (int'(i_ptr) + i) % NUM_REQ;
            if (!o_any && i_req[w_slot]) begin
                o_any           = 1'b1;
                o_grant[w_slot] = 1'b1;
                o_idx           = w_slot[ID_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/int_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : int_alu_arbiter
//  Purpose  : Round-robin sharing of one integer ALU among NUM_REQ thread
//             slots: accept, issue, wait for done (watchdog), respond.
//  Revision : 1.0 - initial release
// ============================================================================
module int_alu_arbiter
    import int_alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    int_alu_arbiter_if.slave  bus,
    output logic              busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t            r_state;
    arb_state_t            w_next_state;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_W-1:0]     r_op1;
    logic [DATA_W-1:0]     r_op2;
    logic [ALU_OP_W-1:0]   r_operation;
    logic [TAG_W-1:0]      r_tag;
    logic [ID_W-1:0]       r_id;
    logic [DATA_W-1:0]     r_resp_data;
    logic [1:0]            r_resp_flag;
    logic                  r_resp_timeout;

    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_W-1:0]       w_idx;
    logic                  w_any;
    logic                  w_accept;
    logic                  w_capture;
    logic                  w_timeout;
    logic [ID_W-1:0]       w_next_ptr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_next_ptr = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + ID_W'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state decode plus one-cycle accept/capture/timeout strobes.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_accept     = 1'b1;
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.alu_done) begin
                    w_capture    = 1'b1;
                    w_next_state = RESP;
                end else begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (bus.alu_done) begin
                    w_capture    = 1'b1;
                    w_next_state = RESP;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_timeout    = 1'b1;
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Request latch, round-robin pointer, watchdog counter and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr       <= '0;
            r_cnt          <= '0;
            r_op1          <= '0;
            r_op2          <= '0;
            r_operation    <= '0;
            r_tag          <= '0;
            r_id           <= '0;
            r_resp_data    <= '0;
            r_resp_flag    <= '0;
            r_resp_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op1       <= bus.req_op1[int'(w_idx)*DATA_W +: DATA_W];
                r_op2       <= bus.req_op2[int'(w_idx)*DATA_W +: DATA_W];
                r_operation <= bus.req_operation[int'(w_idx)*ALU_OP_W +: ALU_OP_W];
                r_tag       <= bus.req_tag[int'(w_idx)*TAG_W +: TAG_W];
                r_id        <= w_idx;
                r_rr_ptr    <= w_next_ptr;
            end
            if (r_state == ISSUE)     r_cnt <= '0;
            else if (r_state == WAIT) r_cnt <= r_cnt + CNT_W'(1);
            if (w_capture) begin
                r_resp_data    <= bus.alu_out;
                r_resp_flag    <= flag_kept(r_operation) ? bus.alu_flag : 2'b00;
                r_resp_timeout <= 1'b0;
            end else if (w_timeout) begin
                r_resp_data    <= '0;
                r_resp_flag    <= 2'b00;
                r_resp_timeout <= 1'b1;
            end
        end
    end

    // Grant is only offered while idle and not being reset.
    assign bus.req_ready     = (r_state == IDLE && !rst) ? w_grant : '0;
    assign bus.alu_en        = (r_state == ISSUE);
    assign bus.alu_op1       = r_op1;
    assign bus.alu_op2       = r_op2;
    assign bus.alu_operation = r_operation;
    assign bus.resp_valid    = (r_state == RESP);
    assign bus.resp_id       = r_id;
    assign bus.resp_tag      = r_tag;
    assign bus.resp_data     = r_resp_data;
    assign bus.resp_flag     = r_resp_flag;
    assign bus.resp_timeout  = r_resp_timeout;
    assign busy              = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_int_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_int_alu_arbiter
//  Purpose  : Directed bench for int_alu_arbiter with a stub ALU that can
//             answer in the issue cycle, after a delay, or never.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_int_alu_arbiter;
    import int_alu_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int TAG_W   = 5;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    always #5 clk = ~clk;

    int_alu_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus ();

    int_alu_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TAG_W   (TAG_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    // Stub ALU: mode 0 = done in issue cycle, 1 = done m_delay cycles after en, 2 = never.
    int          m_mode;
    int          m_delay;
    int          m_cnt;
    logic        m_active;
    logic [31:0] m_out;
    logic [1:0]  m_flag;
    logic        stray;

    function automatic logic [31:0] stub_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:     return a + b;
            OP_SUB:     return a - b;
            OP_AND:     return a & b;
            OP_OR:      return a | b;
            OP_XOR:     return a ^ b;
            OP_NOT:     return ~a;
            OP_WR_HIGH: return {b[15:0], a[15:0]};
            OP_WR_LOW:  return {a[31:16], b[15:0]};
            default:    return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_cnt    <= 0;
        end else if (bus.alu_en && m_mode == 1) begin
            m_active <= 1'b1;
            m_cnt    <= 1;
        end else if (m_active) begin
            if (bus.alu_done) m_active <= 1'b0;
            m_cnt <= m_cnt + 1;
        end
    end

    always_comb begin
        bus.alu_done = stray;
        bus.alu_out  = m_out;
        bus.alu_flag = m_flag;
        if (m_mode == 0) begin
            bus.alu_done = bus.alu_en | stray;
            bus.alu_out  = stub_alu(bus.alu_operation, bus.alu_op1, bus.alu_op2);
            bus.alu_flag = 2'b10;
        end else if (m_mode == 1) begin
            bus.alu_done = stray | (m_active && m_cnt == m_delay);
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_valid();
        bus.req_valid = '0;
    endtask

    task automatic set_req(input int k, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAG_W-1:0] tag);
        bus.req_valid[k]               = 1'b1;
        bus.req_op1[k*32 +: 32]        = a;
        bus.req_op2[k*32 +: 32]        = b;
        bus.req_operation[k*4 +: 4]    = op;
        bus.req_tag[k*TAG_W +: TAG_W]  = tag;
    endtask

    task automatic wait_idle(input string name);
        for (int c = 0; c < 20; c++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check(name, busy, 1'b0);
    endtask

    typedef struct {
        int              k;
        logic [3:0]      op;
        logic [31:0]     a;
        logic [31:0]     b;
        logic [TAG_W-1:0] tag;
        logic [31:0]     exp_data;
        logic [1:0]      exp_flag;
    } vec_t;

    // Single-cycle op through requester v.k, starting and ending at a negedge in IDLE.
    task automatic run_single(input vec_t v);
        logic [3:0] exp_rdy;
        exp_rdy = 4'b0001 << v.k;
        set_req(v.k, v.op, v.a, v.b, v.tag);
        #1;
        check("accept_ready", bus.req_ready, exp_rdy);
        @(negedge clk);
        clear_valid();
        check("issue_en", bus.alu_en, 1'b1);
        check("issue_op1", bus.alu_op1, v.a);
        check("issue_op2", bus.alu_op2, v.b);
        check("issue_operation", bus.alu_operation, v.op);
        check("issue_resp_valid", bus.resp_valid, 1'b0);
        @(negedge clk);
        check("resp_valid", bus.resp_valid, 1'b1);
        check("resp_en_low", bus.alu_en, 1'b0);
        check("resp_data", bus.resp_data, v.exp_data);
        check("resp_flag", bus.resp_flag, v.exp_flag);
        check("resp_id", bus.resp_id, v.k);
        check("resp_tag", bus.resp_tag, v.tag);
        check("resp_timeout", bus.resp_timeout, 1'b0);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("back_idle", busy, 1'b0);
        check("back_resp_valid", bus.resp_valid, 1'b0);
    endtask

    vec_t vecs[7];
    vec_t v_after;
    vec_t v_rst;
    int   rr_exp[6];
    int   got;

    initial begin
        vecs[0] = '{0, OP_XOR,     32'hF0F0_0000, 32'h0FF0_0000, 5'd1,  32'hFF00_0000, 2'b00};
        vecs[1] = '{1, OP_ADD,     32'h0000_0005, 32'h0000_0003, 5'd2,  32'h0000_0008, 2'b10};
        vecs[2] = '{2, OP_AND,     32'hFF00_FF00, 32'h0F0F_0F0F, 5'd3,  32'h0F00_0F00, 2'b00};
        vecs[3] = '{3, OP_SUB,     32'h0000_000A, 32'h0000_0003, 5'd4,  32'h0000_0007, 2'b10};
        vecs[4] = '{1, OP_OR,      32'h0000_00A0, 32'h0000_000B, 5'd5,  32'h0000_00AB, 2'b00};
        vecs[5] = '{0, OP_WR_HIGH, 32'h1234_5678, 32'h0000_ABCD, 5'd31, 32'hABCD_5678, 2'b00};
        vecs[6] = '{3, OP_ADD,     32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 2'b10};
        v_after = '{2, OP_ADD,     32'd100,       32'd23,        5'd4,  32'h0000_007B, 2'b10};
        rr_exp  = '{0, 1, 2, 3, 0, 1};

        rst = 1'b1;
        bus.req_valid = '0; bus.req_op1 = '0; bus.req_op2 = '0;
        bus.req_operation = '0; bus.req_tag = '0; bus.resp_ready = 1'b0;
        m_mode = 0; m_delay = 0; m_out = '0; m_flag = '0; stray = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_req_ready", bus.req_ready, 4'b0000);
        check("rst_alu_en", bus.alu_en, 1'b0);
        check("rst_alu_op1", bus.alu_op1, 32'h0);
        check("rst_resp_valid", bus.resp_valid, 1'b0);
        check("rst_resp_data", bus.resp_data, 32'h0);
        check("rst_resp_timeout", bus.resp_timeout, 1'b0);
        check("rst_busy", busy, 1'b0);

        // Table of single-cycle ops.
        for (int i = 0; i < 7; i++) run_single(vecs[i]);

        // Multi-cycle ADD from requester 2, done 5 cycles after enable.
        m_mode = 1; m_delay = 5; m_out = 32'd7; m_flag = 2'b01;
        set_req(2, OP_ADD, 32'h11, 32'h22, 5'd9);
        #1;
        check("mc_ready", bus.req_ready, 4'b0100);
        @(negedge clk);
        clear_valid();
        check("mc_en", bus.alu_en, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("mc_wait_en", bus.alu_en, 1'b0);
            check("mc_wait_op1", bus.alu_op1, 32'h11);
            check("mc_wait_op2", bus.alu_op2, 32'h22);
            check("mc_wait_resp", bus.resp_valid, 1'b0);
        end
        @(negedge clk);
        check("mc_resp_valid", bus.resp_valid, 1'b1);
        check("mc_resp_data", bus.resp_data, 32'd7);
        check("mc_resp_flag", bus.resp_flag, 2'b01);
        check("mc_resp_id", bus.resp_id, 2);
        check("mc_resp_tag", bus.resp_tag, 5'd9);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("mc_idle", busy, 1'b0);

        // Round robin with all four requesters valid, pointer restarted by reset.
        m_mode = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) set_req(k, OP_ADD, k, 1, 5'(k));
        bus.resp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            #1;
            if (bus.req_ready != '0) begin
                check("rr_onehot", $onehot(bus.req_ready), 1'b1);
                check("rr_order", bus.req_ready, 4'b0001 << rr_exp[got]);
                got++;
            end
            @(negedge clk);
        end
        check("rr_grants", got, 6);
        clear_valid();
        wait_idle("rr_drain");
        bus.resp_ready = 1'b0;

        // Back-pressure: response held for 10 cycles, pointer now at 2.
        set_req(1, OP_OR, 32'hA0, 32'h0B, 5'd3);
        #1;
        check("bp_ready", bus.req_ready, 4'b0010);
        @(negedge clk);
        clear_valid();
        set_req(0, OP_XOR, 32'h1, 32'h3, 5'd6);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", bus.resp_valid, 1'b1);
            check("bp_data", bus.resp_data, 32'hAB);
            check("bp_id", bus.resp_id, 1);
            check("bp_tag", bus.resp_tag, 5'd3);
            check("bp_req_ready", bus.req_ready, 4'b0000);
            check("bp_en", bus.alu_en, 1'b0);
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_released_idle", busy, 1'b0);
        check("bp_next_grant", bus.req_ready, 4'b0001);
        @(negedge clk);
        clear_valid();
        wait_idle("bp_drain");
        bus.resp_ready = 1'b0;

        // Watchdog: ALU never answers.
        m_mode = 2; m_out = 32'hDEAD_BEEF; m_flag = 2'b11;
        set_req(3, OP_MUL, 32'd6, 32'd7, 5'd17);
        #1;
        check("to_ready", bus.req_ready, 4'b1000);
        @(negedge clk);
        clear_valid();
        check("to_en", bus.alu_en, 1'b1);
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            check("to_wait_resp", bus.resp_valid, 1'b0);
            check("to_wait_busy", busy, 1'b1);
        end
        @(negedge clk);
        check("to_resp_valid", bus.resp_valid, 1'b1);
        check("to_flag_set", bus.resp_timeout, 1'b1);
        check("to_data", bus.resp_data, 32'h0);
        check("to_flag", bus.resp_flag, 2'b00);
        check("to_id", bus.resp_id, 3);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        check("stray_busy", busy, 1'b0);
        check("stray_resp", bus.resp_valid, 1'b0);
        m_mode = 0;
        run_single(v_after);

        // Reset while waiting on the ALU.
        m_mode = 2;
        set_req(1, OP_DIV, 32'd50, 32'd5, 5'd12);
        #1;
        check("rw_ready", bus.req_ready, 4'b0010);
        @(negedge clk);
        clear_valid();
        set_req(3, OP_XOR, 32'hFFFF_0000, 32'h00FF_FF00, 5'd21);
        @(negedge clk);
        check("rw_in_wait", busy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_mode = 0;
        #1;
        check("rw_alu_en", bus.alu_en, 1'b0);
        check("rw_busy", busy, 1'b0);
        check("rw_resp_valid", bus.resp_valid, 1'b0);
        check("rw_alu_op1", bus.alu_op1, 32'h0);
        check("rw_alu_operation", bus.alu_operation, 4'h0);
        check("rw_resp_data", bus.resp_data, 32'h0);
        check("rw_req_ready", bus.req_ready, 4'b1000);
        @(negedge clk);
        clear_valid();
        check("rw_issue", bus.alu_en, 1'b1);
        @(negedge clk);
        check("rw_resp_valid2", bus.resp_valid, 1'b1);
        check("rw_resp_id", bus.resp_id, 3);
        check("rw_resp_data2", bus.resp_data, 32'hFF00_FF00);
        check("rw_resp_tag", bus.resp_tag, 5'd21);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("rw_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
